// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the
// 8-way priority / round-robin arbiter.
package arb_pkg;
  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;
endpackage

// File: rtl/pri_arbiter_8_if.sv
// Request/grant bundle between requesting
// engines (master) and the arbiter (slave).
interface pri_arbiter_8_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_vld, timeout
  );
endinterface

// File: rtl/rot_pri_enc.sv
// Rotating priority encoder: bit ptr has top
// priority, then ptr-1, ptr-2, ... wrapping.
module rot_pri_enc
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] enc;

  // rot[7] is vec[ptr]; rot[j] is vec[j+ptr+1] mod 8
  always_comb begin
    rot = '0;
    enc = '0;
    for (int j = 0; j < NREQ; j++) begin
      rot[j] = vec[IDX_W'(j) + ptr + IDX_W'(1)];
    end
    for (int j = 0; j < NREQ; j++) begin
      if (rot[j]) enc = IDX_W'(j);
    end
  end

  assign idx   = enc + ptr + IDX_W'(1);
  assign found = |vec;

endmodule

// File: rtl/pri_arbiter_8.sv
// Registered one-hot arbiter with hold
// timeout and fixed or rotating priority.
module pri_arbiter_8
  import arb_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input logic clk,
  input logic rst,
  pri_arbiter_8_if.slave bus
);

  localparam bit TO_EN = (HOLD_MAX != 0);
  localparam int LIM_I = TO_EN ? HOLD_MAX - 1 : 0;
  localparam logic [CNT_W-1:0] LIM = LIM_I[CNT_W-1:0];
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NREQ - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [NREQ-1:0]  gnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             vld_q;
  logic             to_q;

  logic [IDX_W-1:0] win;
  logic             found;
  logic             own_req;
  logic             hit;
  logic             rel;
  logic             to_rel;

  rot_pri_enc u_enc (
    .vec   (bus.req),
    .ptr   (ptr),
    .idx   (win),
    .found (found)
  );

  always_comb begin
    own_req = bus.req[idx_q];
    hit     = TO_EN && (hold_cnt == LIM);
    rel     = bus.done | ~own_req | hit;
    // done wins over a coincident timeout
    to_rel  = hit & ~bus.done & own_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= TOP;
      hold_cnt <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          to_q <= 1'b0;
          if (found) begin
            state    <= GRANT;
            gnt_q    <= NREQ'(1) << win;
            idx_q    <= win;
            vld_q    <= 1'b1;
            hold_cnt <= '0;
            if (RR_EN) ptr <= win - IDX_W'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            to_q     <= to_rel;
            hold_cnt <= '0;
            if (found) begin
              gnt_q <= NREQ'(1) << win;
              idx_q <= win;
              if (RR_EN) ptr <= win - IDX_W'(1);
            end else begin
              state <= IDLE;
              gnt_q <= '0;
              vld_q <= 1'b0;
            end
          end else begin
            to_q     <= 1'b0;
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_pri_arbiter_8.sv
// Directed + random bench for pri_arbiter_8: a round-robin
// instance (hold 16) and a fixed instance (no timeout).
module tb_pri_arbiter_8;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;

  int checks = 0;
  int failures = 0;

  pri_arbiter_8_if rr_if ();
  pri_arbiter_8_if fx_if ();

  assign rr_if.req  = req;
  assign rr_if.done = done;
  assign fx_if.req  = req;
  assign fx_if.done = done;

  pri_arbiter_8 #(.RR_EN(1'b1), .HOLD_MAX(16), .CNT_W(5)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_if)
  );

  pri_arbiter_8 #(.RR_EN(1'b0), .HOLD_MAX(0), .CNT_W(5)) u_fx (
    .clk (clk),
    .rst (rst),
    .bus (fx_if)
  );

  always #5 clk = ~clk;

  // reference model: index 0 = round-robin, 1 = fixed
  int own [2];
  int mptr [2];
  int cnt [2];
  int lidx [2];
  bit mto [2];

  function automatic int search(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p - k + 8) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1; mptr[m] = 7; cnt[m] = 0;
      lidx[m] = 0; mto[m] = 1'b0;
    end
  endtask

  task automatic model_edge(int m);
    int w;
    int hmax;
    bit rr;
    bit hitm;
    rr = (m == 0);
    hmax = (m == 0) ? 16 : 0;
    if (own[m] < 0 || done || !req[own[m]] ||
        (hmax != 0 && cnt[m] == hmax - 1)) begin
      hitm = (own[m] >= 0) && hmax != 0 && cnt[m] == hmax - 1;
      mto[m] = (own[m] >= 0) && hitm && !done && req[own[m]];
      w = search(req, mptr[m]);
      own[m] = w;
      cnt[m] = 0;
      if (w >= 0) begin
        lidx[m] = w;
        if (rr) mptr[m] = (w + 7) % 8;
      end
    end else begin
      cnt[m]++;
      mto[m] = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] egnt(int m);
    return (own[m] >= 0) ? (8'd1 << own[m]) : 8'd0;
  endfunction

  task automatic check_all();
    chk("rr_gnt", rr_if.gnt, egnt(0));
    chk("rr_idx", {5'd0, rr_if.gnt_idx}, 8'(lidx[0]));
    chk("rr_vld", {7'd0, rr_if.gnt_vld}, {7'd0, own[0] >= 0});
    chk("rr_to", {7'd0, rr_if.timeout}, {7'd0, mto[0]});
    chk("fx_gnt", fx_if.gnt, egnt(1));
    chk("fx_idx", {5'd0, fx_if.gnt_idx}, 8'(lidx[1]));
    chk("fx_vld", {7'd0, fx_if.gnt_vld}, {7'd0, own[1] >= 0});
    chk("fx_to", {7'd0, fx_if.timeout}, {7'd0, mto[1]});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", rr_if.gnt, 8'h00);
    chk("rst_vld", {7'd0, rr_if.gnt_vld}, 8'h00);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // first grant: highest index wins
    req = 8'b1010_0000;
    step();
    chk("t1_gnt", rr_if.gnt, 8'h80);
    chk("t1_idx", {5'd0, rr_if.gnt_idx}, 8'd7);

    // done pulses: rr alternates, fixed stays on 7
    done = 1'b1; step(); done = 1'b0;
    chk("t2_rr5", {5'd0, rr_if.gnt_idx}, 8'd5);
    chk("t3_fx7", {5'd0, fx_if.gnt_idx}, 8'd7);
    step();
    done = 1'b1; step(); done = 1'b0;
    chk("t2_rr7", {5'd0, rr_if.gnt_idx}, 8'd7);
    chk("t3_fx7b", {5'd0, fx_if.gnt_idx}, 8'd7);

    // hold timeout on requester 0
    req = 8'b0000_0001;
    step();
    repeat (15) step();
    chk("t4_pre", {7'd0, rr_if.timeout}, 8'd0);
    step();
    chk("t4_to", {7'd0, rr_if.timeout}, 8'd1);
    chk("t4_idx", {5'd0, rr_if.gnt_idx}, 8'd0);
    chk("t4_fx", {7'd0, fx_if.timeout}, 8'd0);
    step();
    chk("t4_clr", {7'd0, rr_if.timeout}, 8'd0);
    repeat (14) step();
    done = 1'b1; step(); done = 1'b0;
    chk("t4_done", {7'd0, rr_if.timeout}, 8'd0);

    // request drops -> idle
    req = 8'b0000_1000;
    step();
    chk("t5_idx", {5'd0, rr_if.gnt_idx}, 8'd3);
    req = 8'h00;
    step();
    chk("t5_vld", {7'd0, rr_if.gnt_vld}, 8'd0);
    chk("t5_gnt", fx_if.gnt, 8'h00);

    // async reset mid-grant
    req = 8'b0010_0100;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_gnt", rr_if.gnt, 8'h00);
    chk("t6_vld", {7'd0, rr_if.gnt_vld}, 8'd0);
    chk("t6_to", {7'd0, rr_if.timeout}, 8'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_idx", {5'd0, rr_if.gnt_idx}, 8'd5);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0)
        req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      step();
    end
    done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
